sliscp_ctrl: RTL and testbench

SLISCP_CTRL -- requirements
Module: sliscp_ctrl

---
 rtl/sliscp_ctrl.sv | 100 ++++++++++
 tb/tb_sliscp_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sliscp_ctrl.sv
// Step sequencer for the sLiSCP permutation: loads a state, runs NSTEPS datapath steps, pulses done.
// Optional watchdog is compiled in with `define SLISCP_CTRL_WDOG_EN.
module sliscp_ctrl #(
  parameter int WIDTH  = 64,
  parameter int NSTEPS = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*WIDTH-1:0] din,
  output logic               busy,
  output logic               done,
  output logic [4*WIDTH-1:0] dout,
  output logic [4*WIDTH-1:0] step_sin,
  input  logic [4*WIDTH-1:0] step_sout,
  output logic               en_rnd_ctr,
  input  logic               rnd_done,
  output logic [4:0]         step_idx,
  output logic               err
);

  localparam int SW = 4 * WIDTH;
  localparam logic [4:0] LAST_IDX = 5'(NSTEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [SW-1:0] st_q;
  logic [4:0]    idx_q;
  logic          wd_trip;

`ifdef SLISCP_CTRL_WDOG_EN
  logic [5:0] wd_q;
  logic       err_q;

  // Trip on the edge that would take the counter to 63 without a completed step.
  assign wd_trip = (state == RUN) && !rnd_done && (wd_q == 6'd62);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      wd_q <= '0;
    end else if (state == RUN) begin
      if (rnd_done) begin
        wd_q <= '0;
      end else if (wd_trip) begin
        wd_q  <= '0;
        err_q <= 1'b1;
      end else begin
        wd_q <= wd_q + 6'd1;
      end
    end
  end

  assign err = err_q;
`else
  assign wd_trip = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      st_q  <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            st_q  <= din;
            idx_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (rnd_done) begin
            st_q <= step_sout;
            // The last step keeps its index so step_idx never wraps.
            if (idx_q == LAST_IDX) state <= DONE;
            else                   idx_q <= idx_q + 5'd1;
          end else if (wd_trip) begin
            state <= IDLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign en_rnd_ctr = (state == RUN);
  assign dout       = st_q;
  assign step_sin   = st_q;
  assign step_idx   = idx_q;

endmodule

// File: tb/tb_sliscp_ctrl.sv
// Bench for sliscp_ctrl: stub step datapath (adds 1 per step) with a programmable rnd_done period,
// checked against an arithmetic model of the expected latency and result.
module tb_sliscp_ctrl;
  localparam int WIDTH  = 64;
  localparam int NSTEPS = 18;
  localparam int SW     = 4 * WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] din = '0;
  logic          busy, done, en_rnd_ctr, rnd_done, err;
  logic [SW-1:0] dout, step_sin, step_sout;
  logic [4:0]    step_idx;

  sliscp_ctrl #(.WIDTH(WIDTH), .NSTEPS(NSTEPS)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .busy(busy), .done(done),
    .dout(dout), .step_sin(step_sin), .step_sout(step_sout), .en_rnd_ctr(en_rnd_ctr),
    .rnd_done(rnd_done), .step_idx(step_idx), .err(err)
  );

  always #5 clk = ~clk;

  // Stub datapath: round counter runs while enabled, flags a completed step every R cycles.
  int   period = 8;
  logic stall = 1'b0;
  int   rctr = 0;
  always @(posedge clk) begin
    if (!en_rnd_ctr) rctr <= 0;
    else             rctr <= (rctr >= period - 1) ? 0 : rctr + 1;
  end
  assign rnd_done  = en_rnd_ctr && !stall && (rctr == period - 1);
  assign step_sout = step_sin + SW'(1);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] v;
    for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full permutation. Expected: done NSTEPS*r+1 cycles after start, dout = d + NSTEPS,
  // step_idx equals the number of completed steps so far. poke injects ignored starts.
  task automatic run(input logic [SW-1:0] d, input int r, input bit poke, input string tag);
    int k, pulses, en_cnt;
    bit poked;
    logic [SW-1:0] exp;
    exp    = d + SW'(NSTEPS);
    period = r;
    din    = d;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    k = 1; pulses = 0; en_cnt = 0; poked = 1'b0;
    while (!done && k <= NSTEPS * 16 + 4) begin
      start = 1'b0;
      if (busy) begin
        chk({tag, "_idx"}, SW'(step_idx), SW'(pulses));
        if (en_rnd_ctr) en_cnt++;
        if (rnd_done) pulses++;
        if (poke && !poked && step_idx == 5'd5) begin
          start = 1'b1;
          din   = ~d;
          poked = 1'b1;
        end
      end
      tick;
      k++;
    end
    start = 1'b0;
    chk({tag, "_done"}, SW'(done), SW'(1));
    chk({tag, "_lat"}, SW'(k), SW'(NSTEPS * r + 1));
    chk({tag, "_dout"}, dout, exp);
    chk({tag, "_sin"}, step_sin, exp);
    chk({tag, "_encnt"}, SW'(en_cnt), SW'(NSTEPS * r));
    chk({tag, "_busy_done"}, SW'({busy, en_rnd_ctr}), SW'(0));
    chk({tag, "_idx_end"}, SW'(step_idx), SW'(NSTEPS - 1));
    if (poke) begin
      start = 1'b1;
      din   = rand_state();
    end
    tick;
    start = 1'b0;
    chk({tag, "_after"}, SW'({busy, done}), SW'(0));
    tick;
    chk({tag, "_after2"}, SW'({busy, done}), SW'(0));
    chk({tag, "_hold"}, dout, exp);
  endtask

  initial begin
    logic [SW-1:0] d;
    int n;
    bit sawdone;

    // Reset state
    tick;
    tick;
    chk("rst_ctl", SW'({busy, done, en_rnd_ctr, err}), SW'(0));
    chk("rst_dout", dout, '0);
    chk("rst_idx", SW'(step_idx), SW'(0));
    rst = 1'b1;

    run('0, 8, 1'b0, "stub8");
    chk("stub8_eq18", dout, SW'(18));
    run(rand_state(), 1, 1'b0, "rnd1");
    run(rand_state(), 8, 1'b1, "ignore");
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      run(rand_state(), $urandom_range(1, 9), 1'b0, "rand");
    end

    // Reset in the middle of a run
    period = 8;
    d = rand_state();
    din = d;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (step_idx != 5'd9 && n < 500) begin
      tick;
      n++;
    end
    chk("mid_reach9", SW'(step_idx), SW'(9));
    rst = 1'b0;
    #1;
    chk("mid_ctl", SW'({busy, done, en_rnd_ctr, err}), SW'(0));
    chk("mid_dout", dout, '0);
    chk("mid_idx", SW'(step_idx), SW'(0));
    sawdone = 1'b0;
    repeat (3) begin
      tick;
      if (done || busy) sawdone = 1'b1;
    end
    rst = 1'b1;
    tick;
    chk("mid_quiet", SW'({sawdone, busy, done}), SW'(0));
    run(rand_state(), 8, 1'b0, "post_rst");

    // Step datapath stalls after step 3
    period = 8;
    din = rand_state();
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (step_idx != 5'd3 && n < 500) begin
      tick;
      n++;
    end
    chk("wd_reach3", SW'(step_idx), SW'(3));
    stall = 1'b1;
    n = 0;
    sawdone = 1'b0;
`ifdef SLISCP_CTRL_WDOG_EN
    while (!err && n < 200) begin
      tick;
      n++;
      if (done) sawdone = 1'b1;
    end
    chk("wd_edges", SW'(n), SW'(63));
    chk("wd_err", SW'(err), SW'(1));
    chk("wd_busy", SW'(busy), SW'(0));
    chk("wd_nodone", SW'(sawdone), SW'(0));
    tick;
    chk("wd_sticky", SW'(err), SW'(1));
`else
    repeat (100) begin
      tick;
      if (done) sawdone = 1'b1;
    end
    chk("nowd_busy", SW'(busy), SW'(1));
    chk("nowd_err", SW'(err), SW'(0));
    chk("nowd_nodone", SW'(sawdone), SW'(0));
`endif
    stall = 1'b0;
    rst = 1'b0;
    tick;
    chk("final_rst", SW'({busy, err}), SW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
